// File: rtl/mm_lat_mem_pkg.sv
// Shared constants and FSM state type for the latency-modelled main memory.
package mm_lat_mem_pkg;

    localparam int BYTE         = 8;
    localparam int DEF_PA_WIDTH = 32;

    typedef enum logic [1:0] {MM_IDLE, MM_WAIT, MM_RESP} mm_state_t;

    function automatic int blk_width(input int blk_bytes);
        return blk_bytes * BYTE;
    endfunction

endpackage

// File: rtl/mm_lat_mem_store.sv
// Byte array with one block-wide synchronous port; contents are preloaded once and never reset.
module mm_lat_mem_store
    import mm_lat_mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int BLK_BYTES = 16,
    parameter int SEED      = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int BLK_W    = blk_width(BLK_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [BLK_BYTES-1:0] be_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [BLK_W-1:0]     wdata_i,
    output logic [BLK_W-1:0]     rdata_o
);

    typedef logic [BYTE-1:0] mem_t [DEPTH];

    function automatic mem_t preload();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = (SEED != 0) ? (BYTE'(i) ^ 8'hA5) : '0;
        end
        return m;
    endfunction

    mem_t mem_q = preload();
    logic [BLK_W-1:0] rd_blk_d;
    logic [BLK_W-1:0] rdata_q;

    // addr_i is block aligned, so addr_i + k never wraps past the end of the array.
    always_comb begin
        rd_blk_d = '0;
        for (int k = 0; k < BLK_BYTES; k++) begin
            rd_blk_d[k*BYTE +: BYTE] = mem_q[addr_i + AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int k = 0; k < BLK_BYTES; k++) begin
                if (be_i[k]) begin
                    mem_q[addr_i + AW'(k)] <= wdata_i[k*BYTE +: BYTE];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= we_i ? '0 : rd_blk_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mm_lat_mem.sv
// Main-memory model: one outstanding block request, answered LATENCY cycles after accept.
module mm_lat_mem
    import mm_lat_mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int BLK_BYTES = 16,
    parameter int PA_WIDTH  = DEF_PA_WIDTH,
    parameter int LATENCY   = 4,
    parameter int SEED      = 1,
    localparam int BLK_W    = blk_width(BLK_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [PA_WIDTH-1:0]  req_addr,
    input  logic [BLK_BYTES-1:0] req_be,
    input  logic [BLK_W-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BLK_W-1:0]     rsp_rdata,
    output logic                 busy,
    output mm_state_t            dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on
    // ready, and the producer holds its payload stable while valid is high and ready is low.
    mm_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic                 we_q;
    logic [AW-1:0]        base_q;
    logic [BLK_BYTES-1:0] be_q;
    logic [BLK_W-1:0]     wdata_q;

    logic [AW-1:0] req_base;
    logic          mem_en;
    logic          unused_addr_bits;

    assign req_base         = AW'(req_addr) & ~AW'(BLK_BYTES - 1);
    assign unused_addr_bits = ^req_addr;
    assign mem_en           = (state_q == MM_WAIT) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            base_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                MM_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        base_q  <= req_base;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= MM_WAIT;
                    end
                end
                MM_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= MM_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MM_RESP: begin
                    if (rsp_ready) begin
                        state_q <= MM_IDLE;
                    end
                end
                default: state_q <= MM_IDLE;
            endcase
        end
    end

    mm_lat_mem_store #(
        .DEPTH     (DEPTH),
        .BLK_BYTES (BLK_BYTES),
        .SEED      (SEED)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .en_i    (mem_en),
        .we_i    (we_q),
        .be_i    (be_q),
        .addr_i  (base_q),
        .wdata_i (wdata_q),
        .rdata_o (rsp_rdata)
    );

    assign req_ready = (state_q == MM_IDLE);
    assign rsp_valid = (state_q == MM_RESP);
    assign busy      = (state_q != MM_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mm_lat_mem.sv
// Directed bench for mm_lat_mem: two instances (LATENCY 4 and 1) checked against a byte-array model.
module tb_mm_lat_mem;
    import mm_lat_mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int BB    = 16;
    localparam int BW    = BB * 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid_s [2];
    logic          req_ready_s [2];
    logic          req_we_s    [2];
    logic [31:0]   req_addr_s  [2];
    logic [BB-1:0] req_be_s    [2];
    logic [BW-1:0] req_wdata_s [2];
    logic          rsp_valid_s [2];
    logic          rsp_ready_s [2];
    logic [BW-1:0] rsp_rdata_s [2];
    logic          busy_s      [2];
    mm_state_t     dbg_s       [2];

    mm_lat_mem #(.DEPTH(DEPTH), .BLK_BYTES(BB), .PA_WIDTH(32), .LATENCY(4), .SEED(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_we(req_we_s[0]),
        .req_addr(req_addr_s[0]), .req_be(req_be_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]), .rsp_rdata(rsp_rdata_s[0]),
        .busy(busy_s[0]), .dbg_state(dbg_s[0])
    );

    mm_lat_mem #(.DEPTH(DEPTH), .BLK_BYTES(BB), .PA_WIDTH(32), .LATENCY(1), .SEED(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_we(req_we_s[1]),
        .req_addr(req_addr_s[1]), .req_be(req_be_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]), .rsp_rdata(rsp_rdata_s[1]),
        .busy(busy_s[1]), .dbg_state(dbg_s[1])
    );

    // ---------------- scoreboard ----------------
    logic [7:0]    model [2][DEPTH];
    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_err    = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_base(input logic [31:0] addr);
        return int'(addr % DEPTH) & ~(BB - 1);
    endfunction

    function automatic logic [BW-1:0] model_blk(input int sel, input logic [31:0] addr);
        logic [BW-1:0] b;
        int base;
        base = model_base(addr);
        b = '0;
        for (int k = 0; k < BB; k++) b[k*8 +: 8] = model[sel][base + k];
        return b;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the selected DUT idle; returns at a negedge.
    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [BB-1:0] be, input logic [BW-1:0] wdata,
                          input string tag, output logic [BW-1:0] got);
        int k;
        int base;
        logic [BW-1:0] exp;
        base = model_base(addr);
        if (we) begin
            for (int b = 0; b < BB; b++) if (be[b]) model[sel][base + b] = wdata[b*8 +: 8];
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(model_blk(sel, addr));
        end
        check({tag, " req_ready before"}, BW'(req_ready_s[sel]), BW'(1'b1));
        req_valid_s[sel] = 1'b1;
        req_we_s[sel]    = we;
        req_addr_s[sel]  = addr;
        req_be_s[sel]    = be;
        req_wdata_s[sel] = wdata;
        @(posedge clk);
        #1 req_valid_s[sel] = 1'b0;
        req_wdata_s[sel] = ~wdata;
        req_addr_s[sel]  = ~addr;
        @(negedge clk);
        check({tag, " busy after accept"}, BW'(busy_s[sel]), BW'(1'b1));
        check({tag, " req_ready after accept"}, BW'(req_ready_s[sel]), BW'(1'b0));
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (rsp_valid_s[sel]) break;
        end
        check({tag, " latency"}, BW'(k), BW'(lat_of(sel)));
        exp = exp_q.pop_front();
        got = rsp_rdata_s[sel];
        check({tag, " rdata"}, got, exp);
        if (rsp_ready_s[sel]) begin
            @(negedge clk);
            check({tag, " rsp_valid after hs"}, BW'(rsp_valid_s[sel]), BW'(1'b0));
            check({tag, " req_ready after hs"}, BW'(req_ready_s[sel]), BW'(1'b1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [BW-1:0] got;
        logic [BW-1:0] held;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) model[s][i] = 8'(i) ^ 8'hA5;
            req_valid_s[s] = 1'b0; req_we_s[s] = 1'b0; req_addr_s[s] = '0;
            req_be_s[s] = '0; req_wdata_s[s] = '0; rsp_ready_s[s] = 1'b1;
        end

        #2 rst = 1'b1;
        #1;
        check("reset req_ready", BW'(req_ready_s[0]), BW'(1'b1));
        check("reset rsp_valid", BW'(rsp_valid_s[0]), BW'(1'b0));
        check("reset rsp_rdata", rsp_rdata_s[0], '0);
        check("reset busy", BW'(busy_s[0]), BW'(1'b0));
        check("reset state", BW'(dbg_s[0]), BW'(MM_IDLE));
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // 1: preloaded read
        do_req(0, 1'b0, 32'h20, '0, '0, "t1 read 0x20", got);
        check("t1 byte0 const", BW'(got[7:0]), BW'(8'h85));

        // 2: full write then read back
        do_req(0, 1'b1, 32'h40, 16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF, "t2 write", got);
        do_req(0, 1'b0, 32'h40, '0, '0, "t2 read", got);
        check("t2 block const", got, 128'h00112233445566778899AABBCCDDEEFF);

        // 3: single-byte masked write, read via unaligned address
        do_req(0, 1'b1, 32'h40, 16'h0001, 128'h5A, "t3 write", got);
        do_req(0, 1'b0, 32'h4F, '0, '0, "t3 read", got);
        check("t3 block const", got, 128'h00112233445566778899AABBCCDDEE5A);

        // be = 0 write: acks, memory unchanged
        do_req(0, 1'b1, 32'h40, 16'h0000, {BW{1'b1}}, "be0 write", got);
        do_req(0, 1'b0, 32'h40, '0, '0, "be0 read", got);

        // 4: response back-pressure with an ignored request pulse
        rsp_ready_s[0] = 1'b0;
        held = model_blk(0, 32'h30);
        do_req(0, 1'b0, 32'h30, '0, '0, "t4 read", got);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                req_valid_s[0] = 1'b1; req_we_s[0] = 1'b1; req_addr_s[0] = 32'h80;
                req_be_s[0] = 16'hFFFF; req_wdata_s[0] = {BW{1'b1}};
            end else begin
                req_valid_s[0] = 1'b0;
            end
            @(negedge clk);
            check("t4 rsp_valid held", BW'(rsp_valid_s[0]), BW'(1'b1));
            check("t4 rdata held", rsp_rdata_s[0], held);
            check("t4 req_ready low", BW'(req_ready_s[0]), BW'(1'b0));
        end
        req_valid_s[0] = 1'b0;
        rsp_ready_s[0] = 1'b1;
        @(negedge clk);
        check("t4 rsp_valid after hs", BW'(rsp_valid_s[0]), BW'(1'b0));
        check("t4 req_ready after hs", BW'(req_ready_s[0]), BW'(1'b1));
        do_req(0, 1'b0, 32'h80, '0, '0, "t4 ignored write", got);

        // 5: reset two cycles into a write's WAIT phase
        req_valid_s[0] = 1'b1; req_we_s[0] = 1'b1; req_addr_s[0] = 32'h60;
        req_be_s[0] = 16'hFFFF; req_wdata_s[0] = {BW{1'b1}};
        @(posedge clk);
        #1 req_valid_s[0] = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 req_ready", BW'(req_ready_s[0]), BW'(1'b1));
        check("t5 rsp_valid", BW'(rsp_valid_s[0]), BW'(1'b0));
        check("t5 rsp_rdata", rsp_rdata_s[0], '0);
        check("t5 busy", BW'(busy_s[0]), BW'(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        do_req(0, 1'b0, 32'h60, '0, '0, "t5 read after abort", got);

        // 6: address wrap, then LATENCY = 1 instance
        do_req(0, 1'b0, 32'h400, '0, '0, "t6 wrap L4", got);
        check("t6 wrap byte0 const", BW'(got[7:0]), BW'(8'hA5));
        do_req(1, 1'b0, 32'h400, '0, '0, "t6 wrap L1", got);
        check("t6 L1 byte0 const", BW'(got[7:0]), BW'(8'hA5));
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [BW-1:0] d;
            a = 32'($urandom_range(0, 32'hFFFF));
            d = {$urandom, $urandom, $urandom, $urandom};
            do_req(1, 1'b1, a, 16'($urandom_range(0, 16'hFFFF)), d, "t6 L1 rand write", got);
            do_req(1, 1'b0, a, '0, '0, "t6 L1 rand read", got);
        end
        do_req(0, 1'b0, 32'h3F0, '0, '0, "last block", got);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
